problem6_demux: RTL and testbench
=================================

Name: problem6_demux

Overview:
- Registered 1-to-4 distributor: the inverse of the team's 4:1 select-and-register path.
- Accepts one 16-bit word per cycle on a valid/ready handshake and steers it into one of four output holding slots.
- Destination slot is chosen by the i_ctrl field (addressed mode) or by an internal round-robin pointer (rotate mode).
- Each slot presents its word until its consumer acknowledges it. Sits between a single producer and four independent downstream consumers.

Parameters:
- WIDTH, 16, data width of input word and of each output slot
- NCH, 4, number of output channels; fixed at 4 in this revision (i_ctrl is 2 bits)

Ports:
- i_clk  input  1  rising-edge clock
- i_rst  input  1  reset; synchronous, active-high
- i_data  input  WIDTH  input word
- i_valid  input  1  producer offers i_data this cycle
- o_ready  output  1  block accepts the word this cycle (combinational)
- i_ctrl  input  2  destination channel in addressed mode; ignored in rotate mode
- i_mode  input  1  0 = addressed, 1 = rotate (round-robin)
- o_data_0..o_data_3  output  WIDTH each  slot contents (registered)
- o_valid_0..o_valid_3  output  1 each  slot holds an unconsumed word
- i_ack_0..i_ack_3  input  1 each  consumer takes slot word; honoured only when the matching o_valid is 1
- o_ptr  output  2  current round-robin pointer (registered)

Behaviour:
- Reset, applied synchronously at the i_clk edge while i_rst=1:
  - all o_valid_n = 0, all o_data_n = 0, o_ptr = 0.
  - i_rst overrides every other input that cycle; words held at reset are discarded.
- Target channel:
  - sel = i_ctrl when i_mode=0.
  - sel = o_ptr when i_mode=1.
- Ready: o_ready = !o_valid_sel || i_ack_sel. A full slot being drained this cycle can accept a new word in the same cycle (pass-through reload).
- Accept: i_valid && o_ready && !i_rst. On the next edge:
  - o_data_sel <= i_data, o_valid_sel <= 1.
  - Latency: 1 cycle from accept to o_valid visible.
- Drain: i_ack_n && o_valid_n with no accept to slot n clears o_valid_n next edge. o_data_n keeps its last value; it is not cleared.
- Simultaneous ack and accept on the same slot: o_valid stays 1 and o_data takes the new word.
- Ack to an empty slot: no effect.
- Pointer:
  - Advances by 1 mod 4 (3 -> 0 wrap) only on an accepted transfer while i_mode=1.
  - Holds otherwise, including in addressed mode.
  - Switching i_mode does not reset o_ptr.
- Stalls:
  - If slot sel is full and not acked, o_ready=0 and the producer must hold i_data/i_valid.
  - Rotate mode does not skip to a free slot; strict order is guaranteed.
- Other channels are unaffected by activity on sel. Their acks are processed in the same cycle independently.
- i_valid=0: nothing is written and the pointer is unchanged, regardless of o_ready.
- No state machine beyond the per-slot full/empty bit and the pointer. All outputs except o_ready are registered.

Decomposition:
- Shared package problem_pkg holds:
  - NCH, CTRL_W=2
  - mode constants MODE_ADDR=1'b0, MODE_ROT=1'b1
- Sub-module demux_slot (one per channel, generated 4 times):
  - inputs: clk, rst, load, ack, din
  - outputs: dout, valid, ready
  - ready = !valid || ack
- Top level holds:
  - the sel mux
  - the one-hot load decode: load_n = accept && sel==n
  - the pointer register

Test Plan:
- Reset: hold i_rst=1 for 2 cycles with i_valid=1, i_data=16'hFFFF -> all o_valid_n=0, o_data_n=0, o_ptr=0 after the edge; nothing loaded.
- Addressed: i_mode=0, send 16'hA000/A001/A002/A003 with i_ctrl=0,1,2,3, no acks -> each o_data_n=16'hA00n, o_valid_n=1 one cycle after its accept; o_ptr stays 0; a fifth word to i_ctrl=2 sees o_ready=0.
- Rotate with wrap: i_mode=1, slots empty, acks held high, send 6 words 16'h0010..0015 back-to-back -> o_ready=1 every cycle, words land in channels 0,1,2,3,0,1, and o_ptr ends at 2.
- Stall: i_mode=1, o_ptr=1, slot 1 full, i_ack_1=0, i_valid=1 for 3 cycles -> o_ready=0 and o_ptr=1 throughout. Then raise i_ack_1 -> same-cycle accept, o_data_1 = new word, o_valid_1 stays 1, o_ptr=2.
- Simultaneous/ignored: i_ack_3=1 on empty slot 3 -> no change. Accept to ch0 while i_ack_2 drains ch2 -> o_valid_0 rises and o_valid_2 falls on the same edge.
- Reset mid-operation: all four slots full, assert i_rst for 1 cycle with i_valid=1 -> all valids 0 and o_ptr=0 next cycle. Words resume loading into channel 0 after reset deasserts (rotate mode).

Source files
------------

// File: rtl/problem6_demux_pkg.sv
// Shared constants for the 1-to-4 registered distributor.
// Channel count, control width, mode encodings and a one-hot decode helper.
package problem_pkg;

  localparam int NCH    = 4;
  localparam int CTRL_W = 2;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_ROT  = 1'b1;

  function automatic logic [NCH-1:0] onehot(input logic [CTRL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/problem6_demux_if.sv
// Producer and consumer bundle for problem6_demux.
// Signal names are written from the distributor's point of view.
interface problem6_demux_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_ctrl;
  logic             i_mode;

  logic [WIDTH-1:0] o_data_0;
  logic [WIDTH-1:0] o_data_1;
  logic [WIDTH-1:0] o_data_2;
  logic [WIDTH-1:0] o_data_3;
  logic             o_valid_0;
  logic             o_valid_1;
  logic             o_valid_2;
  logic             o_valid_3;
  logic             i_ack_0;
  logic             i_ack_1;
  logic             i_ack_2;
  logic             i_ack_3;
  logic [1:0]       o_ptr;

  modport slave (
    input  i_data, i_valid, i_ctrl, i_mode,
    input  i_ack_0, i_ack_1, i_ack_2, i_ack_3,
    output o_ready, o_ptr,
    output o_data_0, o_data_1, o_data_2, o_data_3,
    output o_valid_0, o_valid_1, o_valid_2, o_valid_3
  );

  modport master (
    output i_data, i_valid, i_ctrl, i_mode,
    output i_ack_0, i_ack_1, i_ack_2, i_ack_3,
    input  o_ready, o_ptr,
    input  o_data_0, o_data_1, o_data_2, o_data_3,
    input  o_valid_0, o_valid_1, o_valid_2, o_valid_3
  );

endinterface

// File: rtl/problem6_demux_slot.sv
// One output holding slot: keeps a word until its consumer acknowledges it.
// A load in the same cycle as an ack replaces the word and keeps the slot full.
module demux_slot #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_ack,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid,
  output logic             o_ready
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_din;
      r_valid <= 1'b1;
    end else if (i_ack && r_valid) begin
      // data is left in place; only the full flag drops
      r_valid <= 1'b0;
    end
  end

  assign o_dout  = r_data;
  assign o_valid = r_valid;
  assign o_ready = !r_valid || i_ack;

endmodule

// File: rtl/problem6_demux.sv
// Registered 1-to-4 distributor: steers each accepted word into the slot chosen
// by i_ctrl (addressed mode) or by the round-robin pointer (rotate mode).
module problem6_demux
  import problem_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  problem6_demux_if.slave  bus
);

  logic [CTRL_W-1:0] r_ptr;
  logic [CTRL_W-1:0] w_sel;
  logic [NCH-1:0]    w_ack;
  logic [NCH-1:0]    w_load;
  logic [NCH-1:0]    w_slot_valid;
  logic [NCH-1:0]    w_slot_ready;
  logic [WIDTH-1:0]  w_dout [NCH];
  logic              w_ready;
  logic              w_accept;

  assign w_ack    = {bus.i_ack_3, bus.i_ack_2, bus.i_ack_1, bus.i_ack_0};
  assign w_sel    = (bus.i_mode == MODE_ROT) ? r_ptr : bus.i_ctrl;
  assign w_ready  = w_slot_ready[w_sel];
  assign w_accept = bus.i_valid && w_ready && !i_rst;
  assign w_load   = w_accept ? onehot(w_sel) : '0;

  for (genvar n = 0; n < NCH; n++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_load[n]),
      .i_ack   (w_ack[n]),
      .i_din   (bus.i_data),
      .o_dout  (w_dout[n]),
      .o_valid (w_slot_valid[n]),
      .o_ready (w_slot_ready[n])
    );
  end

  // Strict rotation: the pointer never skips a busy slot, it just waits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_accept && bus.i_mode == MODE_ROT) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign bus.o_ready   = w_ready;
  assign bus.o_ptr     = r_ptr;
  assign bus.o_data_0  = w_dout[0];
  assign bus.o_data_1  = w_dout[1];
  assign bus.o_data_2  = w_dout[2];
  assign bus.o_data_3  = w_dout[3];
  assign bus.o_valid_0 = w_slot_valid[0];
  assign bus.o_valid_1 = w_slot_valid[1];
  assign bus.o_valid_2 = w_slot_valid[2];
  assign bus.o_valid_3 = w_slot_valid[3];

endmodule

// File: tb/tb_problem6_demux.sv
// Directed bench for problem6_demux: a cycle-by-cycle vector table with
// hand-computed expectations, followed by a short latency/drain sequence.
module tb_problem6_demux;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] data;
    logic [1:0]  ctrl;
    logic        mode;
    logic [3:0]  ack;
    logic        chk_rdy;
    logic        exp_rdy;
    logic [3:0]  exp_valid;
    logic [15:0] exp_d0;
    logic [15:0] exp_d1;
    logic [15:0] exp_d2;
    logic [15:0] exp_d3;
    logic [1:0]  exp_ptr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t tv[$];

  problem6_demux_if #(.WIDTH(16)) bus ();

  problem6_demux #(.WIDTH(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [15:0] d, input logic [1:0] c,
                     input logic m, input logic [3:0] a, input logic cr, input logic er,
                     input logic [3:0] ev, input logic [15:0] d0, input logic [15:0] d1,
                     input logic [15:0] d2, input logic [15:0] d3, input logic [1:0] ep);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.ctrl = c; t.mode = m; t.ack = a;
    t.chk_rdy = cr; t.exp_rdy = er; t.exp_valid = ev;
    t.exp_d0 = d0; t.exp_d1 = d1; t.exp_d2 = d2; t.exp_d3 = d3; t.exp_ptr = ep;
    tv.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] d, input logic [1:0] c,
                       input logic m, input logic [3:0] a);
    rst         = r;
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_ctrl  = c;
    bus.i_mode  = m;
    bus.i_ack_0 = a[0];
    bus.i_ack_1 = a[1];
    bus.i_ack_2 = a[2];
    bus.i_ack_3 = a[3];
  endtask

  function automatic logic [3:0] valids();
    return {bus.o_valid_3, bus.o_valid_2, bus.o_valid_1, bus.o_valid_0};
  endfunction

  initial begin
    drive(1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 4'h0);

    // reset held two cycles with a word on offer
    add(1,1,16'hFFFF,0,0,4'h0, 0,0, 4'b0000, 16'h0000,16'h0000,16'h0000,16'h0000, 2'd0);
    add(1,1,16'hFFFF,0,0,4'h0, 1,1, 4'b0000, 16'h0000,16'h0000,16'h0000,16'h0000, 2'd0);
    // addressed fill, then a stalled fifth word
    add(0,1,16'hA000,0,0,4'h0, 1,1, 4'b0001, 16'hA000,16'h0000,16'h0000,16'h0000, 2'd0);
    add(0,1,16'hA001,1,0,4'h0, 1,1, 4'b0011, 16'hA000,16'hA001,16'h0000,16'h0000, 2'd0);
    add(0,1,16'hA002,2,0,4'h0, 1,1, 4'b0111, 16'hA000,16'hA001,16'hA002,16'h0000, 2'd0);
    add(0,1,16'hA003,3,0,4'h0, 1,1, 4'b1111, 16'hA000,16'hA001,16'hA002,16'hA003, 2'd0);
    add(0,1,16'hA004,2,0,4'h0, 1,0, 4'b1111, 16'hA000,16'hA001,16'hA002,16'hA003, 2'd0);
    add(0,0,16'h0000,2,0,4'hF, 1,1, 4'b0000, 16'hA000,16'hA001,16'hA002,16'hA003, 2'd0);
    // rotate with acks held high, wraps 3 -> 0
    add(0,1,16'h0010,0,1,4'hF, 1,1, 4'b0001, 16'h0010,16'hA001,16'hA002,16'hA003, 2'd1);
    add(0,1,16'h0011,0,1,4'hF, 1,1, 4'b0010, 16'h0010,16'h0011,16'hA002,16'hA003, 2'd2);
    add(0,1,16'h0012,0,1,4'hF, 1,1, 4'b0100, 16'h0010,16'h0011,16'h0012,16'hA003, 2'd3);
    add(0,1,16'h0013,0,1,4'hF, 1,1, 4'b1000, 16'h0010,16'h0011,16'h0012,16'h0013, 2'd0);
    add(0,1,16'h0014,0,1,4'hF, 1,1, 4'b0001, 16'h0014,16'h0011,16'h0012,16'h0013, 2'd1);
    add(0,1,16'h0015,0,1,4'hF, 1,1, 4'b0010, 16'h0014,16'h0015,16'h0012,16'h0013, 2'd2);
    // fill the rest without acks to land at ptr=1 with slot 1 full
    add(0,1,16'h0020,0,1,4'h0, 1,1, 4'b0110, 16'h0014,16'h0015,16'h0020,16'h0013, 2'd3);
    add(0,1,16'h0021,0,1,4'h0, 1,1, 4'b1110, 16'h0014,16'h0015,16'h0020,16'h0021, 2'd0);
    add(0,1,16'h0022,0,1,4'h0, 1,1, 4'b1111, 16'h0022,16'h0015,16'h0020,16'h0021, 2'd1);
    // stall three cycles, then pass-through reload on ack
    add(0,1,16'h0030,0,1,4'h0, 1,0, 4'b1111, 16'h0022,16'h0015,16'h0020,16'h0021, 2'd1);
    add(0,1,16'h0030,0,1,4'h0, 1,0, 4'b1111, 16'h0022,16'h0015,16'h0020,16'h0021, 2'd1);
    add(0,1,16'h0030,0,1,4'h0, 1,0, 4'b1111, 16'h0022,16'h0015,16'h0020,16'h0021, 2'd1);
    add(0,1,16'h0030,0,1,4'h2, 1,1, 4'b1111, 16'h0022,16'h0030,16'h0020,16'h0021, 2'd2);
    // drain 2/3, ack to empty slot 3, then simultaneous load/drain on other slots
    add(0,0,16'h0000,0,1,4'hC, 1,1, 4'b0011, 16'h0022,16'h0030,16'h0020,16'h0021, 2'd2);
    add(0,0,16'h0000,0,0,4'h8, 1,0, 4'b0011, 16'h0022,16'h0030,16'h0020,16'h0021, 2'd2);
    add(0,1,16'h0040,2,0,4'h1, 1,1, 4'b0110, 16'h0022,16'h0030,16'h0040,16'h0021, 2'd2);
    add(0,1,16'h0041,0,0,4'h4, 1,1, 4'b0011, 16'h0041,16'h0030,16'h0040,16'h0021, 2'd2);
    // fill all four, reset mid-operation, resume in rotate mode from channel 0
    add(0,1,16'h0050,2,0,4'h0, 1,1, 4'b0111, 16'h0041,16'h0030,16'h0050,16'h0021, 2'd2);
    add(0,1,16'h0051,3,0,4'h0, 1,1, 4'b1111, 16'h0041,16'h0030,16'h0050,16'h0051, 2'd2);
    add(1,1,16'h0052,0,1,4'h0, 1,0, 4'b0000, 16'h0000,16'h0000,16'h0000,16'h0000, 2'd0);
    add(0,1,16'h0060,0,1,4'h0, 1,1, 4'b0001, 16'h0060,16'h0000,16'h0000,16'h0000, 2'd1);
    add(0,1,16'h0061,0,1,4'h0, 1,1, 4'b0011, 16'h0060,16'h0061,16'h0000,16'h0000, 2'd2);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i].rst, tv[i].valid, tv[i].data, tv[i].ctrl, tv[i].mode, tv[i].ack);
      #1;
      if (tv[i].chk_rdy) chk($sformatf("v%0d ready", i), {31'd0, bus.o_ready}, {31'd0, tv[i].exp_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid", i), {28'd0, valids()}, {28'd0, tv[i].exp_valid});
      chk($sformatf("v%0d data0", i), {16'd0, bus.o_data_0}, {16'd0, tv[i].exp_d0});
      chk($sformatf("v%0d data1", i), {16'd0, bus.o_data_1}, {16'd0, tv[i].exp_d1});
      chk($sformatf("v%0d data2", i), {16'd0, bus.o_data_2}, {16'd0, tv[i].exp_d2});
      chk($sformatf("v%0d data3", i), {16'd0, bus.o_data_3}, {16'd0, tv[i].exp_d3});
      chk($sformatf("v%0d ptr", i), {30'd0, bus.o_ptr}, {30'd0, tv[i].exp_ptr});
    end

    // one-cycle latency: slot 2 not visible before the edge, visible after
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h00AA, 2'd2, 1'b0, 4'h0);
    #1;
    chk("lat ready", {31'd0, bus.o_ready}, 32'd1);
    chk("lat pre valid2", {31'd0, bus.o_valid_2}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat post valid2", {31'd0, bus.o_valid_2}, 32'd1);
    chk("lat post data2", {16'd0, bus.o_data_2}, 32'h00AA);
    // drain keeps the data word in place
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 4'h4);
    @(posedge clk);
    #1;
    chk("drain valid2", {31'd0, bus.o_valid_2}, 32'd0);
    chk("drain data2", {16'd0, bus.o_data_2}, 32'h00AA);
    chk("drain ptr", {30'd0, bus.o_ptr}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
